exmem_ctrl: RTL and testbench

Memory-side slave that serves the single request channel leaving the user-area arbiter, which merges CPU, fir-DMA, matmul-DMA and quicksort-DMA accesses. It backs that channel with a fixed-latency synchronous word memory that stands in for external SDRAM. It adds a one-line, PF_DEPTH-word read prefetch buffer, so that the sequential reads issued by the DMAs mostly complete in 1 cycle.

---
 rtl/exmem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_exmem_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_ctrl.sv
// exmem_ctrl: memory-side slave for the arbitrated user-area request channel.
// Backs the channel with a fixed-latency synchronous word memory and keeps a
// single aligned PF_DEPTH-word read line so sequential DMA reads hit in 1 cycle.
module exmem_ctrl #(
    parameter int MEM_AW   = 13,
    parameter int READ_LAT = 10,
    parameter int PF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       addr,
    input  logic              rw,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    output logic [31:0]       out_data,
    input  logic              pf_flush,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int OFF_W = $clog2(PF_DEPTH);
    localparam int TAG_W = MEM_AW - OFF_W;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(PF_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FETCH,
        RESP
    } state_t;

    state_t state, state_n;

    // Request decode: word index, its line tag and its offset inside the line.
    logic [MEM_AW-1:0] word_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  req_off_w;

    assign word_idx  = addr[MEM_AW+1:2];
    assign req_tag   = word_idx[MEM_AW-1:OFF_W];
    assign req_off_w = word_idx[OFF_W-1:0];

    // Byte-lane and aliased upper address bits carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:MEM_AW+2], addr[1:0]};

    // Prefetch line and fill bookkeeping.
    logic [31:0]         buffer [PF_DEPTH];
    logic                line_valid;
    logic [TAG_W-1:0]    line_tag;
    logic [OFF_W-1:0]    req_off;
    logic [OFF_W-1:0]    iss_cnt;
    logic [OFF_W-1:0]    iss_nxt;
    logic [OFF_W-1:0]    cap_cnt;
    logic [READ_LAT-1:0] vld_sr;
    logic                flush_pend;

    logic accept;
    logic in_line;
    logic rd_strobe;
    logic rd_ret;
    logic fill_done;

    assign accept    = (state == IDLE) && in_valid;
    assign in_line   = line_valid && (req_tag == line_tag);
    assign iss_nxt   = iss_cnt + OFF_W'(1);
    // A read strobe is any memory access without byte enables.
    assign rd_strobe = mem_en && (mem_we == 4'h0);
    // The word strobed READ_LAT cycles ago is on mem_rdata this cycle.
    assign rd_ret    = vld_sr[READ_LAT-1];
    assign fill_done = (state == FETCH) && rd_ret && (cap_cnt == LAST_OFF);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic: write, hit or miss is decided in the accept cycle.
    always_comb begin
        // NOTE: state_n takes a default first so no path leaves it unassigned (no latch).
        state_n = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (rw)           state_n = WRITE;
                    else if (in_line) state_n = RESP;
                    else              state_n = FETCH;
                end
            end
            WRITE:   state_n = RESP;
            FETCH:   if (fill_done) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs, memory strobes, line tag/valid and fill counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 4'h0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            line_valid <= 1'b0;
            line_tag   <= '0;
            req_off    <= '0;
            iss_cnt    <= '0;
            cap_cnt    <= '0;
            vld_sr     <= '0;
            flush_pend <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 4'h0;
            vld_sr    <= (vld_sr << 1) | READ_LAT'(rd_strobe);

            if (pf_flush) line_valid <= 1'b0;
            if (pf_flush && state == FETCH) flush_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (rw) begin
                            mem_en    <= 1'b1;
                            mem_we    <= 4'hF;
                            mem_addr  <= word_idx;
                            mem_wdata <= in_data;
                        end else if (in_line) begin
                            out_valid <= 1'b1;
                            out_data  <= buffer[req_off_w];
                        end else begin
                            // Retarget the line and strobe its first word.
                            line_valid <= 1'b0;
                            line_tag   <= req_tag;
                            req_off    <= req_off_w;
                            iss_cnt    <= '0;
                            cap_cnt    <= '0;
                            flush_pend <= 1'b0;
                            mem_en     <= 1'b1;
                            mem_addr   <= {req_tag, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITE: begin
                    out_valid <= 1'b1;
                end
                FETCH: begin
                    if (iss_cnt != LAST_OFF) begin
                        iss_cnt  <= iss_nxt;
                        mem_en   <= 1'b1;
                        mem_addr <= {line_tag, iss_nxt};
                    end
                    if (rd_ret) cap_cnt <= cap_cnt + OFF_W'(1);
                    if (fill_done) begin
                        // A flush seen at any point of the fill leaves the line unusable.
                        line_valid <= !flush_pend && !pf_flush;
                        out_valid  <= 1'b1;
                        // The last word is still on mem_rdata, not yet in the buffer.
                        out_data   <= (req_off == LAST_OFF) ? mem_rdata : buffer[req_off];
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage: filled from returning words, updated in place by write-through.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is plain storage qualified by line_valid, so it is deliberately not reset.
        if (state == FETCH && rd_ret)     buffer[cap_cnt]   <= mem_rdata;
        else if (accept && rw && in_line) buffer[req_off_w] <= in_data;
    end

endmodule

// File: tb/tb_exmem_ctrl.sv
// tb_exmem_ctrl: directed plus randomized requests against exmem_ctrl, with a
// fixed-latency memory model and a transaction-level reference of the line.
module tb_exmem_ctrl;

    localparam int MEM_AW   = 13;
    localparam int READ_LAT = 10;
    localparam int PF_DEPTH = 4;
    localparam int TIMEOUT  = 40;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [31:0]       addr;
    logic              rw;
    logic [31:0]       in_data;
    logic              out_valid;
    logic [31:0]       out_data;
    logic              pf_flush;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    exmem_ctrl #(
        .MEM_AW  (MEM_AW),
        .READ_LAT(READ_LAT),
        .PF_DEPTH(PF_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .addr     (addr),
        .rw       (rw),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .pf_flush (pf_flush),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // External memory: unwritten words read as index*0x11, data appears
    // exactly READ_LAT cycles after a read strobe, junk otherwise.
    logic [31:0] ext_wr [int];
    logic [31:0] pipe_d [READ_LAT];
    logic        pipe_v [READ_LAT];
    logic [31:0] junk;

    always @(posedge clk) begin
        for (int i = READ_LAT - 1; i > 0; i--) begin
            pipe_d[i] <= pipe_d[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
        pipe_v[0] <= mem_en && (mem_we == 4'h0);
        pipe_d[0] <= ext_wr.exists(int'(mem_addr)) ? ext_wr[int'(mem_addr)]
                                                   : 32'(mem_addr) * 32'h11;
        if (mem_en && mem_we == 4'hF) ext_wr[int'(mem_addr)] = mem_wdata;
        junk <= $urandom;
    end

    assign mem_rdata = pipe_v[READ_LAT-1] ? pipe_d[READ_LAT-1] : junk;

    // Reference: memory contents as the requester sees them, and the line.
    logic [31:0] ref_wr [int];
    bit          m_valid;
    int          m_base;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    function automatic logic [31:0] ref_word(input int w);
        return ref_wr.exists(w) ? ref_wr[w] : 32'(w) * 32'h11;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_out_valid"}, 32'(out_valid), 32'h0);
        check({pfx, "_out_data"},  out_data,       32'h0);
        check({pfx, "_mem_en"},    32'(mem_en),    32'h0);
        check({pfx, "_mem_we"},    32'(mem_we),    32'h0);
        check({pfx, "_mem_addr"},  32'(mem_addr),  32'h0);
        check({pfx, "_mem_wdata"}, mem_wdata,      32'h0);
    endtask

    // One request: flush_req is the cycle offset from accept at which
    // pf_flush pulses (-1 for none).
    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int flush_req);
        int          widx, base, exp_lat, exp_en, lat, en_cnt, flush_k;
        bit          exp_hit, pat_ok;
        logic [31:0] exp_data, got;

        widx     = int'(a[MEM_AW+1:2]);
        base     = widx - (widx % PF_DEPTH);
        exp_hit  = !w && m_valid && (m_base == base);
        exp_lat  = w ? 2 : (exp_hit ? 1 : PF_DEPTH + READ_LAT + 1);
        exp_en   = w ? 1 : (exp_hit ? 0 : PF_DEPTH);
        exp_data = w ? 32'h0 : ref_word(widx);
        flush_k  = flush_req;
        if (flush_k >= exp_lat) flush_k = exp_lat - 1;
        if (flush_k == 0 && !w && !exp_hit) flush_k = 1;

        @(posedge clk); #1;
        check("idle_out_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b1;
        rw       = w;
        addr     = a;
        in_data  = d;
        pf_flush = (flush_k == 0);

        lat    = -1;
        en_cnt = 0;
        pat_ok = 1'b1;
        got    = 32'h0;
        for (int k = 1; k <= TIMEOUT && lat < 0; k++) begin
            @(posedge clk); #1;
            pf_flush = (flush_k == k);
            if (mem_en) begin
                en_cnt++;
                if (w)
                    pat_ok = pat_ok && (k == 1) && (mem_we == 4'hF) &&
                             (int'(mem_addr) == widx) && (mem_wdata == d);
                else
                    pat_ok = pat_ok && (k == en_cnt) && (mem_we == 4'h0) &&
                             (int'(mem_addr) == base + k - 1);
            end
            if (out_valid) begin
                lat      = k;
                got      = out_data;
                in_valid = 1'b0;
            end
        end
        pf_flush = 1'b0;
        in_valid = 1'b0;

        check(w ? "wr_latency" : (exp_hit ? "hit_latency" : "miss_latency"),
              32'(lat), 32'(exp_lat));
        check(w ? "wr_ack_data" : "rd_data", got, exp_data);
        check("mem_strobe_count", 32'(en_cnt), 32'(exp_en));
        check("mem_strobe_pattern", 32'(pat_ok), 32'h1);

        if (w) ref_wr[widx] = d;
        else if (!exp_hit) begin
            m_valid = 1'b1;
            m_base  = base;
        end
        if (flush_k >= 0) m_valid = 1'b0;
    endtask

    initial begin
        int          widx, fk;
        bit          w, ov_seen, en_seen;
        logic [31:0] a, d;

        m_valid  = 1'b0;
        m_base   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        rw       = 1'b0;
        addr     = '0;
        in_data  = '0;
        pf_flush = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom);
            rw       = 1'($urandom);
            addr     = $urandom;
            in_data  = $urandom;
            pf_flush = 1'($urandom);
        end
        check_outputs_zero("rst");
        in_valid = 1'b0;
        pf_flush = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed sequence.
        do_req(1'b0, 32'h3800_0000, 32'h0, -1);          // cold miss, words 0..3
        do_req(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, -1);  // write word 4
        do_req(1'b0, 32'h3800_0014, 32'h0, -1);          // miss, 0x55
        do_req(1'b0, 32'h3800_0018, 32'h0, -1);          // hit, 0x66
        do_req(1'b0, 32'h3800_001C, 32'h0, -1);          // hit, 0x77
        do_req(1'b0, 32'h3800_0010, 32'h0, -1);          // hit, written word
        do_req(1'b1, 32'h3800_001C, 32'h1234_5678, -1);  // write-through
        do_req(1'b0, 32'h3800_001C, 32'h0, -1);          // hit, 0x12345678

        @(posedge clk); #1;
        pf_flush = 1'b1;
        @(posedge clk); #1;
        pf_flush = 1'b0;
        m_valid  = 1'b0;
        do_req(1'b0, 32'h3800_0018, 32'h0, -1);          // miss after flush

        do_req(1'b0, 32'h3800_0040, 32'h0, 5);           // flush during fill
        do_req(1'b0, 32'h3800_0044, 32'h0, -1);          // miss again
        do_req(1'b0, 32'h3800_0048, 32'h0, 0);           // hit, flush at accept
        do_req(1'b0, 32'h3800_004C, 32'h0, -1);          // miss
        do_req(1'b0, 32'h3800_7FFC, 32'h0, -1);          // last line of memory
        do_req(1'b0, 32'hC801_7FF0, 32'h0, -1);          // aliased, same line

        // Reset in the middle of a fill.
        @(posedge clk); #1;
        in_valid = 1'b1;
        rw       = 1'b0;
        addr     = 32'h3800_0020;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_valid = 1'b0;
        ov_seen = 1'b0;
        en_seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            ov_seen = ov_seen || out_valid;
            en_seen = en_seen || mem_en;
        end
        check("aborted_out_valid", 32'(ov_seen), 32'h0);
        check("aborted_mem_en", 32'(en_seen), 32'h0);
        do_req(1'b0, 32'h3800_0020, 32'h0, -1);          // fresh miss, 0x88

        // Randomized traffic, concentrated on a few lines to mix hits and misses.
        for (int i = 0; i < 80; i++) begin
            w    = ($urandom_range(9) < 3);
            widx = ($urandom_range(9) < 7) ? int'($urandom_range(31))
                                           : int'($urandom_range(8191, 8184));
            a    = $urandom;
            a[MEM_AW+1:2] = widx[MEM_AW-1:0];
            d    = $urandom;
            fk   = ($urandom_range(9) == 0) ? int'($urandom_range(15)) : -1;
            do_req(w, a, d, fk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
